// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock run/halt/step sequencer.
package cpu_clk_pkg;

  localparam int CPU_CLK_DIV_W = 8;

  typedef enum logic [1:0] {
    ST_HALTED    = 2'd0,
    ST_RUN       = 2'd1,
    ST_HALT_PEND = 2'd2,
    ST_STEP      = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the switch/debug side (master) and cpu_clk_ctrl (slave).
interface cpu_clk_if
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W = CPU_CLK_DIV_W
) ();

  logic [DIV_W-1:0] div_val;
  logic             run;
  logic             step_req;
  logic             instr_done;
  logic             cpu_ce;
  logic             cpu_clk_out;
  logic             halted;
  logic             step_ack;

  modport master (
    output div_val, run, step_req, instr_done,
    input  cpu_ce, cpu_clk_out, halted, step_ack
  );

  modport slave (
    input  div_val, run, step_req, instr_done,
    output cpu_ce, cpu_clk_out, halted, step_ack
  );

endinterface

// File: rtl/cpu_clk_ctrl_ce_gen.sv
// Period counter with shadowed divide ratio; emits one-cycle ce and a ce-toggled square wave.
module cpu_ce_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_div_val,
  output logic             o_ce,
  output logic             o_clk_out
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_sh;
  logic             r_clk_out;

  assign o_ce      = i_enable && (r_cnt == r_div_sh);
  assign o_clk_out = r_clk_out;

  // While disabled the shadow tracks div_val, so it holds the ratio seen on the leaving edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_div_sh  <= '0;
      r_clk_out <= 1'b0;
    end else if (!i_enable) begin
      r_cnt    <= '0;
      r_div_sh <= i_div_val;
    end else if (o_ce) begin
      r_cnt     <= '0;
      r_div_sh  <= i_div_val;
      r_clk_out <= ~r_clk_out;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step sequencer producing the CPU clock enable.
// Optional ce_count pulse counter enabled by CPU_CLK_CTRL_PERF_EN.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W = CPU_CLK_DIV_W
) (
  input  logic        clk,
  input  logic        rst,
  cpu_clk_if.slave    bus
`ifdef CPU_CLK_CTRL_PERF_EN
  ,
  output logic [15:0] ce_count
`endif
);

  state_t           r_state;
  logic             r_halted;
  logic             r_step_ack;
  logic             w_active;
  logic             w_ce;
  logic             w_clk_out;
  logic [DIV_W-1:0] w_div_val;

  assign w_active  = (r_state != ST_HALTED);
  assign w_div_val = bus.div_val;

  cpu_ce_gen #(
    .DIV_W (DIV_W)
  ) u_ce_gen (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (w_active),
    .i_div_val (w_div_val),
    .o_ce      (w_ce),
    .o_clk_out (w_clk_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_HALTED;
      r_halted   <= 1'b1;
      r_step_ack <= 1'b0;
    end else begin
      r_step_ack <= 1'b0;
      unique case (r_state)
        ST_HALTED: begin
          if (bus.run) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end else if (bus.step_req) begin
            r_state  <= ST_STEP;
            r_halted <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!bus.run) r_state <= ST_HALT_PEND;
        end
        // Boundary wins over a re-asserted run in the same cycle.
        ST_HALT_PEND: begin
          if (w_ce && bus.instr_done) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (bus.run) begin
            r_state <= ST_RUN;
          end
        end
        ST_STEP: begin
          if (w_ce && bus.instr_done) begin
            r_state    <= ST_HALTED;
            r_halted   <= 1'b1;
            r_step_ack <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_HALTED;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cpu_ce      = w_ce;
  assign bus.cpu_clk_out = w_clk_out;
  assign bus.halted      = r_halted;
  assign bus.step_ack    = r_step_ack;

`ifdef CPU_CLK_CTRL_PERF_EN
  logic [15:0] r_ce_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ce_count <= '0;
    end else if (w_ce) begin
      r_ce_count <= r_ce_count + 16'd1;
    end
  end

  assign ce_count = r_ce_count;
`endif

endmodule
